// File: rtl/dds_wave_gen.sv
// DDS waveform source: phase accumulator feeding a two-stage shaping pipeline (sine/triangle/sawtooth/square).
// Optional amplitude-scaling third stage is built when AMP_SCALE_EN is defined.
module dds_wave_gen #(
   parameter int    PHASE_W  = 16,
   parameter int    ADDR_W   = 5,
   parameter int    DATA_W   = 8,
   parameter string LUT_FILE = "sin_quarter.hex"
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               freq_load,
   input  logic [PHASE_W-1:0] freq_word,
   input  logic               phase_clr,
   input  logic [1:0]         mode,
`ifdef AMP_SCALE_EN
   input  logic [7:0]         amp_scale,
`endif
   output logic [DATA_W-1:0]  wave_out,
   output logic               wave_valid,
   output logic               wrap
);

   typedef enum logic [1:0] {
      MODE_SINE   = 2'b00,
      MODE_TRI    = 2'b01,
      MODE_SAW    = 2'b10,
      MODE_SQUARE = 2'b11
   } mode_t;

   localparam int Q       = 1 << (ADDR_W - 2);
   localparam int AMP_MAX = (1 << (DATA_W - 1)) - 1;
   localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};
   localparam longint HALF_PI_Q30 = 64'sd1686629713;
`ifdef AMP_SCALE_EN
   localparam int VLAT = 4;
`else
   localparam int VLAT = 3;
`endif

   generate
      if (PHASE_W < DATA_W + 1 || PHASE_W < ADDR_W || ADDR_W < 3 || LUT_FILE == "") begin : g_bad_params
         $error("dds_wave_gen: unsupported parameter combination");
      end
   endgenerate

   // Quarter-wave table entries, computed at elaboration with the same rounding as the LUT_FILE image
   // so the build never depends on a file search path. Taylor series in Q30 fixed point.
   function automatic logic [DATA_W-2:0] sin_entry(input int k);
      longint x;
      longint x2;
      longint term;
      longint sum;
      longint scaled;
      x    = (HALF_PI_Q30 * longint'(k)) / longint'(Q);
      x2   = (x * x) >>> 30;
      term = x;
      sum  = x;
      for (int n = 1; n <= 10; n++) begin
         term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
         sum  = sum + term;
      end
      scaled = (sum * longint'(AMP_MAX) + (longint'(1) <<< 29)) >>> 30;
      return (DATA_W-1)'(scaled);
   endfunction

   logic [DATA_W-2:0] sine_rom [0:Q];

   for (genvar k = 0; k <= Q; k++) begin : g_rom
      localparam logic [DATA_W-2:0] ENTRY = sin_entry(k);
      assign sine_rom[k] = ENTRY;
   end

   logic [PHASE_W-1:0] freq_reg;
   logic [PHASE_W-1:0] acc;
   logic [PHASE_W:0]   acc_sum;

   assign acc_sum = {1'b0, acc} + {1'b0, freq_reg};

   // The frequency register updates after the add, so a same-cycle load and step uses the old word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         freq_reg <= '0;
      end else if (freq_load) begin
         freq_reg <= freq_word;
      end
   end

   // Phase accumulator with clear taking priority over advance; wrap reports the carry of this update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc  <= '0;
         wrap <= 1'b0;
      end else if (phase_clr) begin
         acc  <= '0;
         wrap <= 1'b0;
      end else if (en) begin
         acc  <= acc_sum[PHASE_W-1:0];
         wrap <= acc_sum[PHASE_W];
      end else begin
         wrap <= 1'b0;
      end
   end

   logic [ADDR_W-1:0] s1_addr;
   logic [ADDR_W-3:0] quad_k;
   logic [ADDR_W-2:0] rom_idx;

   assign s1_addr = acc[PHASE_W-1 -: ADDR_W];
   assign quad_k  = s1_addr[ADDR_W-3:0];

   // Odd quadrants walk the quarter table backwards; index Q is the peak entry.
   always_comb begin
      rom_idx = {1'b0, quad_k};
      if (s1_addr[ADDR_W-2]) begin
         rom_idx = (ADDR_W-1)'(Q) - {1'b0, quad_k};
      end
   end

   logic [DATA_W:0]   s1_top;
   mode_t             s1_mode;
   logic              s1_neg;
   logic [DATA_W-2:0] s1_rom;

   // Only the top DATA_W+1 phase bits are needed by the non-sine shapes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_top  <= '0;
         s1_mode <= MODE_SINE;
         s1_neg  <= 1'b0;
         s1_rom  <= '0;
      end else begin
         s1_top  <= acc[PHASE_W-1 -: DATA_W+1];
         s1_mode <= mode_t'(mode);
         s1_neg  <= s1_addr[ADDR_W-1];
         s1_rom  <= sine_rom[rom_idx];
      end
   end

   logic [DATA_W-1:0] wave_next;
   logic [DATA_W-1:0] wave_s2;

   always_comb begin
      wave_next = MID;
      case (s1_mode)
         MODE_SINE:   wave_next = s1_neg ? MID - {1'b0, s1_rom} : MID + {1'b0, s1_rom};
         MODE_TRI:    wave_next = s1_top[DATA_W] ? ~s1_top[DATA_W-1:0] : s1_top[DATA_W-1:0];
         MODE_SAW:    wave_next = s1_top[DATA_W:1];
         MODE_SQUARE: wave_next = s1_top[DATA_W] ? '0 : '1;
         default:     wave_next = MID;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wave_s2 <= MID;
      end else begin
         wave_s2 <= wave_next;
      end
   end

`ifdef AMP_SCALE_EN
   logic signed [DATA_W:0]   amp_diff;
   logic signed [DATA_W+9:0] amp_prod;
   logic [DATA_W-1:0]        wave_s3;

   // Scale around mid-scale; the arithmetic shift floors negative excursions.
   always_comb begin
      amp_diff = $signed({1'b0, wave_s2}) - $signed({1'b0, MID});
      amp_prod = (DATA_W+10)'(amp_diff) * (DATA_W+10)'($signed({1'b0, amp_scale}));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wave_s3 <= MID;
      end else begin
         wave_s3 <= DATA_W'((DATA_W+10)'($signed({1'b0, MID})) + (amp_prod >>> 8));
      end
   end

   assign wave_out = wave_s3;
`else
   assign wave_out = wave_s2;
`endif

   logic [VLAT-1:0] valid_pipe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_pipe <= '0;
      end else begin
         valid_pipe <= {valid_pipe[VLAT-2:0], en};
      end
   end

   assign wave_valid = valid_pipe[VLAT-1];

endmodule
